perf_counter_bank: RTL and testbench

Synthesizable, parametrised event-counter bank for the pipelined CPU. It counts run cycles and up to NUM_EVT per-cycle pipeline events (stall, flush, retire, ...) while `start_i` is high. A cycle budget stops counting automatically. Software or a bench reads frozen snapshots through a one-cycle request/acknowledge port, so stall/flush statistics no longer require a simulation-only monitor.

---
 rtl/perf_counter_bank.sv | 69 ++++++
 tb/tb_perf_counter_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: run-cycle and event counters with cycle budget, shadow snapshots and 1-cycle read port
module perf_counter_bank #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W = 32,
  parameter int MAX_CYCLES = 30,
  parameter int SATURATE = 1,
  localparam int SEL_W = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clr_i,
  input  logic               snap_i,
  input  logic               rd_req_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic               rd_ack_o,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               done_o
);
  localparam int N = NUM_EVT + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next_state;
  logic [CNT_W-1:0] live [N];
  logic [CNT_W-1:0] shadow [N];
  logic [CNT_W-1:0] nxt [N];
  logic [N-1:0] inc, top;
  logic done_hit;
  assign inc = {1'b1, evt_i} & {N{state == RUN}};
  always_comb begin
    for (int k = 0; k < N; k++) begin
      top[k] = &live[k];
      nxt[k] = top[k] ? (SATURATE != 0 ? live[k] : '0) : live[k] + 1'b1;
    end
  end
  // the cycle counter always increments in RUN, so the budget is checked on its next value
  assign done_hit = state == RUN && MAX_CYCLES != 0 && nxt[NUM_EVT] == CNT_W'(MAX_CYCLES);
  always_comb begin
    next_state = clr_i ? IDLE :
                 state == IDLE ? (start_i ? RUN : IDLE) :
                 state == RUN ? (done_hit ? DONE : start_i ? RUN : IDLE) : DONE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      for (int k = 0; k < N; k++) begin
        live[k] <= '0;
        shadow[k] <= '0;
      end
      ovf_o <= '0;
      rd_ack_o <= 1'b0;
      rd_data_o <= '0;
    end else begin
      state <= next_state;
      for (int k = 0; k < N; k++) begin
        if (snap_i) shadow[k] <= live[k];
        if (clr_i) live[k] <= '0;
        else if (inc[k]) live[k] <= nxt[k];
      end
      ovf_o <= clr_i ? '0 : ovf_o | (inc & top);
      rd_ack_o <= rd_req_i;
      rd_data_o <= rd_req_i && rd_sel_i <= SEL_W'(NUM_EVT) ? shadow[rd_sel_i] : '0;
    end
  end
  assign cycle_o = live[NUM_EVT];
  assign done_o = state == DONE;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed stimulus; read results checked by a queue-based monitor
module tb_perf_counter_bank;
  logic clk = 0, rst = 0, start = 0, clr = 0, snap = 0;
  logic [3:0] evt = '0;
  logic [2:0] sel = '0;
  logic sel_s = 0;
  logic [2:0] req = '0;
  logic ack0, ack1, ack2, done0, done1, done2;
  logic [31:0] data0, cyc0;
  logic [3:0] data1, cyc1, data2, cyc2;
  logic [4:0] ovf0;
  logic [1:0] ovf1, ovf2;
  int checks = 0, errors = 0;
  logic [31:0] q0[$];
  logic [3:0] q1[$], q2[$];
  logic [3:0] pat [10] = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};

  always #5 clk = ~clk;

  perf_counter_bank u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clr_i(clr), .snap_i(snap),
    .rd_req_i(req[0]), .rd_sel_i(sel), .rd_ack_o(ack0), .rd_data_o(data0),
    .cycle_o(cyc0), .ovf_o(ovf0), .done_o(done0));
  perf_counter_bank #(.NUM_EVT(1), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt[0:0]), .clr_i(clr), .snap_i(snap),
    .rd_req_i(req[1]), .rd_sel_i(sel_s), .rd_ack_o(ack1), .rd_data_o(data1),
    .cycle_o(cyc1), .ovf_o(ovf1), .done_o(done1));
  perf_counter_bank #(.NUM_EVT(1), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(0)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt[0:0]), .clr_i(clr), .snap_i(snap),
    .rd_req_i(req[2]), .rd_sel_i(sel_s), .rd_ack_o(ack2), .rd_data_o(data2),
    .cycle_o(cyc2), .ovf_o(ovf2), .done_o(done2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] e);
    start = s;
    evt = e;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [3:0] e);
    step(1, 0);
    repeat (n - 1) step(1, e);
    step(0, e);
  endtask

  task automatic snapshot();
    snap = 1;
    step(0, 0);
    snap = 0;
  endtask

  task automatic clear();
    clr = 1;
    step(0, 0);
    clr = 0;
  endtask

  task automatic rd0(input logic [2:0] s, input logic [31:0] e);
    req[0] = 1;
    sel = s;
    q0.push_back(e);
    step(0, 0);
    req[0] = 0;
  endtask

  task automatic rd1(input logic s, input logic [3:0] e);
    req[1] = 1;
    sel_s = s;
    q1.push_back(e);
    step(0, 0);
    req[1] = 0;
  endtask

  task automatic rd2(input logic s, input logic [3:0] e);
    req[2] = 1;
    sel_s = s;
    q2.push_back(e);
    step(0, 0);
    req[2] = 0;
  endtask

  // monitor: every ack pops its instance's queue; data must be zero when no ack
  always @(negedge clk) begin
    if (ack0) begin
      if (q0.size() == 0) chk("u0_unexpected_ack", 1, 0);
      else chk("u0_rd_data", data0, q0.pop_front());
    end else chk("u0_idle_data", data0, 0);
    if (ack1) begin
      if (q1.size() == 0) chk("u1_unexpected_ack", 1, 0);
      else chk("u1_rd_data", data1, q1.pop_front());
    end else chk("u1_idle_data", data1, 0);
    if (ack2) begin
      if (q2.size() == 0) chk("u2_unexpected_ack", 1, 0);
      else chk("u2_rd_data", data2, q2.pop_front());
    end else chk("u2_idle_data", data2, 0);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    step(0, 0);
    step(0, 0);
    rst = 1;
    chk("rst_cycle", cyc0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ack", ack0, 0);
    chk("rst_cycle_small", cyc1, 0);
    // basic count: 10 run cycles, ch0 x3, ch1 x2
    step(1, 0);
    for (int i = 0; i < 9; i++) step(1, pat[i]);
    step(0, pat[9]);
    chk("basic_cycle", cyc0, 10);
    chk("basic_done", done0, 0);
    snapshot();
    rd0(0, 3);
    rd0(1, 2);
    rd0(4, 10);
    rd0(7, 0);
    rd1(0, 3);
    rd1(1, 10);
    rd2(0, 3);
    // budget stop at 30 cycles
    clear();
    chk("clr_cycle", cyc0, 0);
    step(1, 0);
    repeat (29) step(1, 4'b0100);
    chk("budget_pre_done", done0, 0);
    chk("budget_pre_cycle", cyc0, 29);
    step(1, 4'b0100);
    chk("budget_done", done0, 1);
    chk("budget_cycle", cyc0, 30);
    repeat (10) step(1, 4'b0100);
    chk("budget_frozen_cycle", cyc0, 30);
    chk("budget_frozen_done", done0, 1);
    snapshot();
    rd0(2, 30);
    rd0(4, 30);
    rd0(0, 0);
    clear();
    chk("budget_clr_done", done0, 0);
    chk("budget_clr_cycle", cyc0, 0);
    chk("budget_clr_ovf", ovf0, 0);
    chk("budget_clr_ovf_small", ovf1, 0);
    rd0(2, 30);
    // saturate vs wrap: 20 increments into 4-bit counters
    run(20, 4'b1111);
    chk("sat_cycle", cyc1, 15);
    chk("sat_ovf", ovf1, 2'b11);
    chk("wrap_cycle", cyc2, 4);
    chk("wrap_ovf", ovf2, 2'b11);
    chk("wide_cycle", cyc0, 20);
    chk("wide_ovf", ovf0, 0);
    snapshot();
    rd1(0, 15);
    rd1(1, 15);
    rd2(0, 4);
    rd2(1, 4);
    // pause: 1(5)/0(5)/1(5); RUN persists one cycle after start drops
    clear();
    repeat (5) step(1, 4'b0001);
    step(0, 0);
    repeat (4) step(0, 4'b0001);
    chk("pause_mid_cycle", cyc0, 5);
    repeat (5) step(1, 4'b0001);
    step(0, 0);
    chk("pause_cycle", cyc0, 10);
    snapshot();
    rd0(0, 8);
    rd0(3, 0);
    // snapshot ordering: shadow 2, live 7, then snap+clr+read together
    clear();
    run(2, 4'b0001);
    snapshot();
    run(5, 4'b0001);
    chk("order_live", cyc0, 7);
    snap = 1;
    clr = 1;
    req[0] = 1;
    sel = 0;
    q0.push_back(2);
    step(0, 0);
    snap = 0;
    clr = 0;
    req[0] = 0;
    chk("order_clr_cycle", cyc0, 0);
    rd0(0, 7);
    rd0(4, 7);
    snapshot();
    rd0(0, 0);
    // reset mid-run with a read in flight
    step(1, 0);
    repeat (3) step(1, 4'b0001);
    chk("mid_cycle", cyc0, 3);
    rst = 0;
    req[0] = 1;
    sel = 4;
    step(1, 4'b0001);
    rst = 1;
    req[0] = 0;
    chk("mid_rst_ack", ack0, 0);
    chk("mid_rst_data", data0, 0);
    chk("mid_rst_cycle", cyc0, 0);
    chk("mid_rst_ovf", ovf0, 0);
    chk("mid_rst_done", done0, 0);
    step(1, 4'b0001);
    chk("resume_first", cyc0, 0);
    step(1, 4'b0001);
    chk("resume_count", cyc0, 1);
    step(0, 0);
    rd0(4, 0);
    repeat (4) step(0, 0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
